// File: rtl/sprite_blit_if.sv
// Bundle between sprite_blit and its CPU, main-memory and VRAM neighbours.
// slave is the drawer's view; master is the surrounding system's view.
interface sprite_blit_if #(
   parameter int X_BITS     = 7,
   parameter int Y_BITS     = 6,
   parameter int ADDR_WIDTH = 12,
   parameter int VA_WIDTH   = X_BITS + Y_BITS
);
   logic                  start;
   logic                  cls_start;
   logic                  wide;
   logic                  clip;
   logic [ADDR_WIDTH-1:0] I;
   logic [7:0]            x_in;
   logic [7:0]            y_in;
   logic [3:0]            nibbles;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic [7:0]            mem_d;
   logic                  scan_stall;
   logic [VA_WIDTH-1:0]   vram_raddr;
   logic                  vram_q;
   logic                  vram_we;
   logic [VA_WIDTH-1:0]   vram_waddr;
   logic                  vram_d;
   logic                  busy;
   logic                  done;
   logic                  col;

   modport master (
      output start, cls_start, wide, clip,
      output I, x_in, y_in, nibbles,
      output mem_d, scan_stall, vram_q,
      input  mem_raddr, vram_raddr,
      input  vram_we, vram_waddr, vram_d,
      input  busy, done, col
   );

   modport slave (
      input  start, cls_start, wide, clip,
      input  I, x_in, y_in, nibbles,
      input  mem_d, scan_stall, vram_q,
      output mem_raddr, vram_raddr,
      output vram_we, vram_waddr, vram_d,
      output busy, done, col
   );
endinterface

// File: rtl/sprite_blit.sv
// XOR sprite drawer and full-screen clear for a 1bpp VRAM.
// Sprite rows come from main memory; pixels are read-modify-written.
module sprite_blit #(
   parameter int X_BITS     = 7,
   parameter int Y_BITS     = 6,
   parameter int ADDR_WIDTH = 12,
   parameter int VA_WIDTH   = X_BITS + Y_BITS
) (
   input  logic         clk,
   input  logic         rst_n,
   sprite_blit_if.slave bus
);

   localparam int XW = X_BITS + 1;
   localparam int YW = Y_BITS + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_PIX   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_CLS   = 3'd4;

   logic [2:0]            r_state;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_col;
   logic                  r_wide;
   logic                  r_clip;
   logic [ADDR_WIDTH-1:0] r_I;
   logic [X_BITS-1:0]     r_x0;
   logic [Y_BITS-1:0]     r_y0;
   logic [4:0]            r_nrows;
   logic [4:0]            r_row;
   logic [3:0]            r_k;
   logic [1:0]            r_fph;
   logic                  r_dph;
   logic [15:0]           r_sh;
   logic [ADDR_WIDTH-1:0] r_mraddr;
   logic                  r_wpend;
   logic                  r_wdraw;
   logic [VA_WIDTH-1:0]   r_waddr;
   logic [VA_WIDTH-1:0]   r_cls_cnt;

   logic [X_BITS:0]       w_xs;
   logic [Y_BITS:0]       w_ys;
   logic                  w_skip;
   logic [VA_WIDTH-1:0]   w_pa;
   logic                  w_last_k;
   logic [4:0]            w_row_nx;
   logic                  w_row_last;
   logic [5:0]            w_off;
   logic [ADDR_WIDTH-1:0] w_fnext;
   logic [4:0]            w_nrows_in;
   logic                  w_hit;
   logic                  w_unused;

   // Extra top bit of each sum marks a pixel past the screen edge.
   assign w_xs = {1'b0, r_x0} + XW'(r_k);
   assign w_ys = {1'b0, r_y0} + YW'(r_row);

   assign w_skip = r_clip & (w_xs[X_BITS] | w_ys[Y_BITS]);
   assign w_pa   = {w_ys[Y_BITS-1:0], w_xs[X_BITS-1:0]};

   assign w_last_k   = r_wide ? (r_k == 4'd15) : (r_k == 4'd7);
   assign w_row_nx   = r_row + 5'd1;
   assign w_row_last = (w_row_nx == r_nrows);

   assign w_off   = r_wide ? {w_row_nx, 1'b0}
                           : {1'b0, w_row_nx};
   assign w_fnext = r_I + ADDR_WIDTH'(w_off);

   assign w_nrows_in = bus.wide ? 5'd16
                                : {1'b0, bus.nibbles};

   assign w_hit    = r_wpend & r_wdraw & bus.vram_q;
   assign w_unused = ^{bus.x_in, bus.y_in};

   assign bus.mem_raddr  = r_mraddr;
   assign bus.vram_raddr = w_pa;
   assign bus.vram_we    = r_wpend;
   assign bus.vram_waddr = r_waddr;
   assign bus.vram_d     = r_wpend & r_wdraw & ~bus.vram_q;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.col        = r_col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_col     <= 1'b0;
         r_wide    <= 1'b0;
         r_clip    <= 1'b0;
         r_I       <= '0;
         r_x0      <= '0;
         r_y0      <= '0;
         r_nrows   <= '0;
         r_row     <= '0;
         r_k       <= '0;
         r_fph     <= '0;
         r_dph     <= 1'b0;
         r_sh      <= '0;
         r_mraddr  <= '0;
         r_wpend   <= 1'b0;
         r_wdraw   <= 1'b0;
         r_waddr   <= '0;
         r_cls_cnt <= '0;
      end else begin
         r_done  <= 1'b0;
         r_wpend <= 1'b0;
         r_wdraw <= 1'b0;
         if (w_hit)
            r_col <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (bus.cls_start | bus.start) begin
                  r_busy  <= 1'b1;
                  r_col   <= 1'b0;
                  r_wide  <= bus.wide;
                  r_clip  <= bus.clip;
                  r_I     <= bus.I;
                  r_x0    <= bus.x_in[X_BITS-1:0];
                  r_y0    <= bus.y_in[Y_BITS-1:0];
                  r_nrows <= w_nrows_in;
                  r_row   <= '0;
                  r_k     <= '0;
                  r_fph   <= '0;
                  r_dph   <= 1'b0;
               end
               if (bus.cls_start) begin
                  r_state   <= S_CLS;
                  r_cls_cnt <= '0;
               end else if (bus.start) begin
                  if (w_nrows_in == 5'd0) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state  <= S_FETCH;
                     r_mraddr <= bus.I;
                  end
               end
            end

            // Memory data lags its address by one cycle.
            S_FETCH: begin
               r_fph <= r_fph + 2'd1;
               if (r_wide) begin
                  if (r_fph == 2'd0)
                     r_mraddr <= r_mraddr + ADDR_WIDTH'(1);
                  if (r_fph == 2'd1)
                     r_sh[15:8] <= bus.mem_d;
                  if (r_fph == 2'd2) begin
                     r_sh[7:0] <= bus.mem_d;
                     r_k       <= '0;
                     r_state   <= S_PIX;
                  end
               end else if (r_fph == 2'd1) begin
                  r_sh    <= {bus.mem_d, 8'h00};
                  r_k     <= '0;
                  r_state <= S_PIX;
               end
            end

            S_PIX: begin
               if (!bus.scan_stall) begin
                  if (r_sh[15] & ~w_skip) begin
                     r_wpend <= 1'b1;
                     r_wdraw <= 1'b1;
                     r_waddr <= w_pa;
                  end
                  r_sh <= {r_sh[14:0], 1'b0};
                  r_k  <= r_k + 4'd1;
                  if (w_last_k) begin
                     r_row <= w_row_nx;
                     if (w_row_last) begin
                        r_state <= S_DRAIN;
                        r_dph   <= 1'b0;
                     end else begin
                        r_state  <= S_FETCH;
                        r_fph    <= '0;
                        r_mraddr <= w_fnext;
                     end
                  end
               end
            end

            S_CLS: begin
               if (!bus.scan_stall) begin
                  r_wpend   <= 1'b1;
                  r_waddr   <= r_cls_cnt;
                  r_cls_cnt <= r_cls_cnt + VA_WIDTH'(1);
                  if (&r_cls_cnt) begin
                     r_state <= S_DRAIN;
                     r_dph   <= 1'b0;
                  end
               end
            end

            // First cycle lets the last write land; second signals done.
            S_DRAIN: begin
               r_dph <= 1'b1;
               if (r_dph) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blit.sv
// Scoreboard bench for sprite_blit: expected VRAM writes and done
// events are queued by the stimulus and checked by a monitor.
module tb_sprite_blit;

   localparam int W = 128;
   localparam int H = 64;
   localparam int NPIX = W * H;

   typedef struct packed {
      int   t0;
      int   lat;
      logic col;
   } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vram_init = 1'b0;
   logic stall_q = 1'b0;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;
   bit   sb_on = 1'b1;

   logic [7:0]  mem [0:4095];
   logic        vram [0:NPIX-1];
   bit          shadow [0:NPIX-1];
   logic [13:0] wq [$];
   done_t       dq [$];

   sprite_blit_if #(
      .X_BITS(7), .Y_BITS(6), .ADDR_WIDTH(12)
   ) bus ();

   sprite_blit #(
      .X_BITS(7), .Y_BITS(6), .ADDR_WIDTH(12)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      stall_q <= bus.scan_stall;
   end

   always @(posedge clk)
      bus.mem_d <= mem[bus.mem_raddr];

   always @(posedge clk) begin
      if (vram_init) begin
         for (int i = 0; i < NPIX; i++)
            vram[i] <= i[0];
      end else begin
         bus.vram_q <= vram[bus.vram_raddr];
         if (bus.vram_we)
            vram[bus.vram_waddr] <= bus.vram_d;
      end
   end

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] got,
                      input logic [31:0] want);
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   initial begin : mon
      logic [13:0] w;
      done_t e;
      forever begin
         @(negedge clk);
         if (sb_on && bus.vram_we) begin
            nchk++;
            if (wq.size() == 0) begin
               nerr++;
               $display("FAIL vram_write unexpected addr %0d d %0b",
                        bus.vram_waddr, bus.vram_d);
            end else begin
               w = wq.pop_front();
               if ({bus.vram_waddr, bus.vram_d} !== w) begin
                  nerr++;
                  $display("FAIL vram_write got addr %0d d %0b want addr %0d d %0b",
                           bus.vram_waddr, bus.vram_d, w[13:1], w[0]);
               end
            end
         end
         if (stall_q) begin
            nchk++;
            if (bus.vram_we !== 1'b0) begin
               nerr++;
               $display("FAIL stall_write got we %0b want 0", bus.vram_we);
            end
         end
         if (bus.done) begin
            nchk++;
            if (dq.size() == 0) begin
               nerr++;
               $display("FAIL done unexpected at cycle %0d", cyc);
            end else begin
               e = dq.pop_front();
               if (cyc - e.t0 != e.lat || bus.col !== e.col ||
                   bus.busy !== 1'b0) begin
                  nerr++;
                  $display("FAIL done got lat %0d col %0b busy %0b want lat %0d col %0b busy 0",
                           cyc - e.t0, bus.col, bus.busy, e.lat, e.col);
               end
            end
         end
      end
   end

   task automatic model_draw(input int base, input int x0, input int y0,
                             input bit wd, input bit cl, input int n,
                             output bit ec);
      int rows, cols, x, y, a;
      logic [7:0] b;
      ec = 1'b0;
      rows = wd ? 16 : n;
      cols = wd ? 16 : 8;
      for (int r = 0; r < rows; r++) begin
         for (int k = 0; k < cols; k++) begin
            b = wd ? mem[base + 2 * r + k / 8] : mem[base + r];
            x = (x0 % W) + k;
            y = (y0 % H) + r;
            if (!(cl && (x >= W || y >= H))) begin
               x = x % W;
               y = y % H;
               a = y * W + x;
               if (b[7 - k % 8]) begin
                  wq.push_back({a[12:0], ~shadow[a]});
                  if (shadow[a])
                     ec = 1'b1;
                  shadow[a] = ~shadow[a];
               end
            end
         end
      end
   endtask

   task automatic issue(input int base, input int x, input int y,
                        input bit wd, input bit cl, input int n,
                        input bit cls);
      @(negedge clk);
      bus.I         = base[11:0];
      bus.x_in      = x[7:0];
      bus.y_in      = y[7:0];
      bus.wide      = wd;
      bus.clip      = cl;
      bus.nibbles   = n[3:0];
      bus.start     = 1'b1;
      bus.cls_start = cls;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.cls_start = 1'b0;
      chk(bus.busy === 1'b1, "busy_set", {31'd0, bus.busy}, 1);
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (dq.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (dq.size() != 0) begin
         nchk++;
         nerr++;
         $display("FAIL done_timeout got none want done within %0d", budget);
         dq.delete();
      end
      @(negedge clk);
      chk(wq.size() == 0, "writes_left", wq.size(), 0);
      wq.delete();
   endtask

   task automatic run_draw(input int base, input int x, input int y,
                           input bit wd, input bit cl, input int n,
                           input int st_at, input int st_len);
      bit ec;
      int rows, lat;
      model_draw(base, x, y, wd, cl, n, ec);
      rows = wd ? 16 : n;
      lat  = (rows == 0) ? 2 :
             rows * (wd ? 19 : 10) + 2 + st_len;
      issue(base, x, y, wd, cl, n, 1'b0);
      dq.push_back('{t0: cyc, lat: lat, col: ec});
      if (st_len > 0) begin
         repeat (st_at) @(negedge clk);
         bus.scan_stall = 1'b1;
         repeat (st_len) @(negedge clk);
         bus.scan_stall = 1'b0;
      end
      wait_done(lat + 50);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.start      = 1'b0;
      bus.cls_start  = 1'b0;
      bus.wide       = 1'b0;
      bus.clip       = 1'b0;
      bus.I          = '0;
      bus.x_in       = '0;
      bus.y_in       = '0;
      bus.nibbles    = '0;
      bus.scan_stall = 1'b0;
      for (int i = 0; i < 4096; i++)
         mem[i] = 8'h00;
      for (int i = 0; i < NPIX; i++)
         shadow[i] = i[0];
      mem[12'h100] = 8'hA5;
      mem[12'h200] = 8'hFF;
      mem[12'h201] = 8'hFF;
      for (int i = 0; i < 32; i++)
         mem[12'h400 + i] = 8'hFF;
      mem[12'h500] = 8'hC3;

      vram_init = 1'b1;
      repeat (3) @(negedge clk);
      vram_init = 1'b0;
      chk(bus.busy === 1'b0, "rst_busy", {31'd0, bus.busy}, 0);
      chk(bus.done === 1'b0, "rst_done", {31'd0, bus.done}, 0);
      chk(bus.col === 1'b0, "rst_col", {31'd0, bus.col}, 0);
      chk(bus.vram_we === 1'b0, "rst_we", {31'd0, bus.vram_we}, 0);
      chk(bus.vram_d === 1'b0, "rst_d", {31'd0, bus.vram_d}, 0);
      chk(bus.mem_raddr === 12'd0, "rst_mraddr", bus.mem_raddr, 0);
      chk(bus.vram_waddr === 13'd0, "rst_waddr", bus.vram_waddr, 0);
      rst_n = 1'b1;

      // Clear wins over a simultaneous draw; a start while busy is dropped.
      for (int i = 0; i < NPIX; i++) begin
         wq.push_back({i[12:0], 1'b0});
         shadow[i] = 1'b0;
      end
      issue(12'h100, 0, 0, 1'b0, 1'b0, 1, 1'b1);
      dq.push_back('{t0: cyc, lat: NPIX + 2, col: 1'b0});
      repeat (20) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(NPIX + 100);

      run_draw(12'h100, 0, 0, 1'b0, 1'b0, 1, 0, 0);
      run_draw(12'h100, 0, 0, 1'b0, 1'b0, 1, 0, 0);

      run_draw(12'h200, 124, 63, 1'b0, 1'b0, 2, 0, 0);
      run_draw(12'h200, 124, 63, 1'b0, 1'b1, 2, 0, 0);

      run_draw(12'h400, 10, 10, 1'b1, 1'b0, 0, 0, 0);

      run_draw(12'h500, 20, 5, 1'b0, 1'b0, 1, 3, 5);

      run_draw(12'h600, 30, 30, 1'b0, 1'b0, 0, 0, 0);

      // Abort a 16x16 draw over lit pixels with an async reset.
      sb_on = 1'b0;
      issue(12'h400, 10, 10, 1'b1, 1'b0, 0, 1'b0);
      repeat (50) @(negedge clk);
      chk(bus.col === 1'b1, "col_pre_rst", {31'd0, bus.col}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk(bus.busy === 1'b0, "arst_busy", {31'd0, bus.busy}, 0);
      chk(bus.vram_we === 1'b0, "arst_we", {31'd0, bus.vram_we}, 0);
      chk(bus.col === 1'b0, "arst_col", {31'd0, bus.col}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sb_on = 1'b1;

      run_draw(12'h100, 0, 40, 1'b0, 1'b0, 1, 0, 0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/sprite_blit.md
Name: sprite_blit

Overview:
Parametrised successor to the CHIP-8 sprite drawer. It supports SCHIP-style screens (default 128x64) and 8xN or 16x16 sprites, with a per-draw wrap or clip mode. It XORs sprite bytes from main memory into a 1-bit-per-pixel VRAM by read-modify-write, reports collision, and performs full-screen clear. It sits between the CPU core, main memory and the VRAM, and yields the VRAM read port to scanout whenever scanout needs it.

Parameters:
X_BITS, 7, log2 screen width; width W = 2^X_BITS, minimum 4
Y_BITS, 6, log2 screen height; H = 2^Y_BITS
ADDR_WIDTH, 12, main memory address width
VA_WIDTH, X_BITS+Y_BITS, VRAM address width; address = {y,x}

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  draw request pulse; sampled only in IDLE
cls_start  in  1  clear request pulse; sampled only in IDLE
wide  in  1  1 = 16x16 sprite (32 bytes, 2 per row, MSB byte first); 0 = 8xN
clip  in  1  1 = clip at screen edges; 0 = wrap
I  in  ADDR_WIDTH  sprite base address
x_in  in  8  start x; used modulo W
y_in  in  8  start y; used modulo H
nibbles  in  4  row count N for 8xN; ignored when wide=1
mem_raddr  out  ADDR_WIDTH  main memory read address; data returned 1 cycle later
mem_d  in  8  main memory read data
scan_stall  in  1  scanout owns the VRAM read port this cycle
vram_raddr  out  VA_WIDTH  VRAM read address; q returned 1 cycle later
vram_q  in  1  VRAM read data
vram_we  out  1  VRAM write enable
vram_waddr  out  VA_WIDTH  VRAM write address
vram_d  out  1  VRAM write data
busy  out  1  operation in progress
done  out  1  one-cycle pulse at end of a draw or clear
col  out  1  sticky collision flag

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, col, vram_we, vram_d = 0; all addresses = 0. An interrupted draw or clear leaves VRAM partially updated; this is accepted.
- States: IDLE, FETCH, PIX, DRAIN, CLS.
- Request capture in IDLE:
  - cls_start has priority over start when both are high; the losing request is dropped.
  - Requests arriving while busy=1 are ignored.
  - On accept, all inputs are latched, col is cleared, and busy=1 from the next cycle.
- Zero-row draw: start with wide=0 and nibbles=0 makes no memory or VRAM accesses. done pulses 2 cycles after the accepting edge; col=0.
- FETCH: reads the row's bytes from I+r (8-wide) or I+2r and I+2r+1 (16-wide), then latches them into a row shift register. Takes 2 cycles for 8-wide, 3 for 16-wide. Never stalled.
- PIX: one pixel per cycle, MSB first.
  - Cycle k: drive vram_raddr = {y0+r, x0+k}.
  - Cycle k+1, if the sprite bit is 1: vram_we=1, same waddr, vram_d = ~vram_q; col is set if vram_q=1.
  - Sprite bits of 0 produce no write.
- Coordinates in PIX:
  - clip=0: x and y wrap modulo W and H.
  - clip=1: a pixel with x0+k >= W or y0+r >= H is skipped (no write) but still consumes its cycle.
- Stall: when scan_stall=1 in PIX or CLS, no new read or write is issued and the pixel/address counters hold. A write already scheduled from a prior read still completes.
- Hazards: addresses within one row are distinct because W >= 16. Read-after-write across rows is safe because each FETCH gap is at least 2 cycles.
- After the last pixel: PIX→FETCH for the next row, or PIX→DRAIN after the last row.
- DRAIN: completes the final write, then done=1 for one cycle with busy=0 in that same cycle, and the block returns to IDLE.
- Unstalled draw latency from accepting edge to done: 8xN = 10N+2 cycles; 16x16 = 306 cycles. Each stall cycle adds 1.
- CLS:
  - Writes vram_d=0 to addresses 0 .. 2^VA_WIDTH-1 in order, one per unstalled cycle.
  - col stays 0.
  - done pulses 2 cycles after the last write is issued; unstalled latency is 2^VA_WIDTH+2.
- col holds its value after done until the next accepted request.
- mem_raddr is held stable outside FETCH.

Test Plan:
- Reset during a 16x16 draw at cycle 50 → busy=0, vram_we=0, col=0 immediately. A following start is accepted normally.
- VRAM all 0; draw 8x1 with byte 0xA5 at (0,0) → writes at x = 0,2,5,7 with d=1 only, col=0, done at cycle 12. Repeating the same draw restores 0 there and gives col=1.
- 8x2 at x=124, y=63, clip=0 → pixels wrap to x = 124..127 and 0..3, and row 2 lands at y=0. With clip=1 → only x = 124..127 on y=63 are written.
- wide=1 with 32 bytes of 0xFF at (10,10) → 256 writes over a 16x16 area, done at cycle 306.
- Assert scan_stall for 5 cycles mid-row → no VRAM accesses during the stall, the pixel order is unchanged, and done arrives 5 cycles later than unstalled.
- cls_start and start in the same cycle → clear only, 8192 writes of 0, done at cycle 8194. A start issued while busy is ignored.
